// File: rtl/axis_fifo_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_fifo_reg_if
//  Purpose  : AXI-Stream bundle (tdata/tkeep/tlast/tvalid/tready) shared by
//             the slave and master sides of axis_fifo_reg.
//  Modports : master - drives tdata/tkeep/tlast/tvalid, receives tready
//             slave  - receives tdata/tkeep/tlast/tvalid, drives tready
//  Revision : 1.0 - initial release
// ============================================================================
interface axis_fifo_reg_if #(
    parameter int PAR_WDATA_BYTE = 2
);
    logic [8*PAR_WDATA_BYTE-1:0] tdata;
    logic [PAR_WDATA_BYTE-1:0]   tkeep;
    logic                        tlast;
    logic                        tvalid;
    logic                        tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_fifo_reg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_fifo_reg
//  Purpose  : DEPTH-entry registered AXI-Stream buffer carrying tdata, tkeep
//             and tlast, with fill-level, almost-full and stored-packet-count
//             status and a synchronous flush. No combinational path exists
//             between the slave and master sides.
//  Ports    : aclk        - clock, rising edge
//             areset      - asynchronous active-high reset
//             flush       - synchronous flush of all contents
//             s_axis      - AXI-Stream input  (slave modport)
//             m_axis      - AXI-Stream output (master modport)
//             level       - number of stored beats
//             almost_full - level >= PAR_AFULL
//             pkt_cnt     - number of stored beats with tlast = 1
//  Revision : 1.0 - initial release
// ============================================================================
module axis_fifo_reg #(
    parameter int PAR_WDATA_BYTE = 2,
    parameter int PAR_DEPTH      = 4,
    parameter int PAR_AFULL      = 3
) (
    input  wire logic                           aclk,
    input  wire logic                           areset,
    input  wire logic                           flush,
    axis_fifo_reg_if.slave                      s_axis,
    axis_fifo_reg_if.master                     m_axis,
    output logic [$clog2(PAR_DEPTH+1)-1:0]      level,
    output logic                                almost_full,
    output logic [$clog2(PAR_DEPTH+1)-1:0]      pkt_cnt
);
    localparam int c_DW = 8 * PAR_WDATA_BYTE;
    localparam int c_KW = PAR_WDATA_BYTE;
    localparam int c_AW = $clog2(PAR_DEPTH);
    localparam int c_LW = $clog2(PAR_DEPTH + 1);

    // Storage (not reset; validity is tracked by the pointers alone)
    logic [c_DW-1:0] r_mem_data [PAR_DEPTH];
    logic [c_KW-1:0] r_mem_keep [PAR_DEPTH];
    logic            r_mem_last [PAR_DEPTH];

    // Pointers carry one extra wrap bit to distinguish full from empty
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic [c_LW-1:0] r_pkt_cnt;
    logic            r_afull;
    logic            r_tready;

    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_push_last;
    logic            w_pop_last;
    logic [c_AW:0]   w_wr_nxt;
    logic [c_AW:0]   w_rd_nxt;
    logic [c_LW-1:0] w_level_nxt;
    logic [c_LW-1:0] w_pkt_nxt;
    logic            w_full_nxt;

    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Handshakes are qualified only by registered state, so tready never
    // depends on m_axis.tready and tvalid never depends on s_axis.
    assign w_push      = s_axis.tvalid & r_tready;
    assign w_pop       = ~w_empty & m_axis.tready;
    assign w_push_last = w_push & s_axis.tlast;
    assign w_pop_last  = w_pop & m_axis.tlast;

    always_comb begin
        w_wr_nxt    = r_wr_ptr + (c_AW+1)'(w_push);
        w_rd_nxt    = r_rd_ptr + (c_AW+1)'(w_pop);
        w_level_nxt = r_level + c_LW'(w_push) - c_LW'(w_pop);
        w_pkt_nxt   = r_pkt_cnt + c_LW'(w_push_last) - c_LW'(w_pop_last);
        w_full_nxt  = (w_wr_nxt[c_AW-1:0] == w_rd_nxt[c_AW-1:0]) &&
                      (w_wr_nxt[c_AW] != w_rd_nxt[c_AW]);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_pkt_cnt <= '0;
            r_afull   <= 1'b0;
            r_tready  <= 1'b0;
        end else if (flush) begin
            // Flush wins over any push or pop offered in the same cycle
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_pkt_cnt <= '0;
            r_afull   <= 1'b0;
            r_tready  <= 1'b1;
        end else begin
            r_wr_ptr  <= w_wr_nxt;
            r_rd_ptr  <= w_rd_nxt;
            r_level   <= w_level_nxt;
            r_pkt_cnt <= w_pkt_nxt;
            r_afull   <= (w_level_nxt >= c_LW'(PAR_AFULL));
            r_tready  <= ~w_full_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push && !flush) begin
            r_mem_data[r_wr_ptr[c_AW-1:0]] <= s_axis.tdata;
            r_mem_keep[r_wr_ptr[c_AW-1:0]] <= s_axis.tkeep;
            r_mem_last[r_wr_ptr[c_AW-1:0]] <= s_axis.tlast;
        end
    end

    assign s_axis.tready = r_tready;
    assign m_axis.tvalid = ~w_empty;
    assign m_axis.tdata  = r_mem_data[r_rd_ptr[c_AW-1:0]];
    assign m_axis.tkeep  = r_mem_keep[r_rd_ptr[c_AW-1:0]];
    assign m_axis.tlast  = r_mem_last[r_rd_ptr[c_AW-1:0]];

    assign level       = r_level;
    assign almost_full = r_afull;
    assign pkt_cnt     = r_pkt_cnt;
endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_fifo_reg
//  Purpose  : Self-checking bench for axis_fifo_reg against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_fifo_reg;
    localparam int BYTES = 2;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;
    localparam int LW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [8*BYTES-1:0] d;
        logic [BYTES-1:0]   k;
        logic               l;
    } beat_t;

    logic          aclk   = 1'b0;
    logic          areset = 1'b1;
    logic          flush  = 1'b0;
    logic [LW-1:0] level;
    logic [LW-1:0] pkt_cnt;
    logic          almost_full;

    axis_fifo_reg_if #(.PAR_WDATA_BYTE(BYTES)) s_if ();
    axis_fifo_reg_if #(.PAR_WDATA_BYTE(BYTES)) m_if ();

    axis_fifo_reg #(
        .PAR_WDATA_BYTE (BYTES),
        .PAR_DEPTH      (DEPTH),
        .PAR_AFULL      (AFULL)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .flush       (flush),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .level       (level),
        .almost_full (almost_full),
        .pkt_cnt     (pkt_cnt)
    );

    always #5 aclk = ~aclk;

    int    vectors     = 0;
    int    miscompares = 0;
    beat_t q[$];
    bit    exp_rdy     = 1'b0;
    int    obs_pops    = 0;
    bit    hold        = 1'b0;
    beat_t held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pkts();
        int n = 0;
        foreach (q[i]) if (q[i].l) n++;
        return n;
    endfunction

    task automatic check_state();
        beat_t cur;
        cur = {m_if.tdata, m_if.tkeep, m_if.tlast};
        chk("level", 32'(level), 32'(q.size()));
        chk("level_range", 32'(level <= LW'(DEPTH)), 32'd1);
        chk("pkt_cnt", 32'(pkt_cnt), 32'(model_pkts()));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= AFULL));
        chk("m_tvalid", 32'(m_if.tvalid), 32'(q.size() != 0));
        chk("s_tready", 32'(s_if.tready), 32'(exp_rdy));
        if (q.size() > 0) chk("m_payload", 32'(cur), 32'(q[0]));
        if (hold) chk("m_stable", 32'(cur), 32'(held));
    endtask

    // One clock cycle: decide handshakes from the model, advance, check.
    task automatic step();
        bit    push;
        bit    pop;
        beat_t b;
        push = s_if.tvalid && exp_rdy;
        pop  = m_if.tready && (q.size() > 0);
        b    = {s_if.tdata, s_if.tkeep, s_if.tlast};
        hold = (q.size() > 0) && !m_if.tready && !flush;
        held = {m_if.tdata, m_if.tkeep, m_if.tlast};
        if (m_if.tvalid && m_if.tready && !flush) obs_pops++;
        @(posedge aclk);
        #1;
        if (flush) q.delete();
        else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(b);
        end
        exp_rdy = (q.size() != DEPTH);
        check_state();
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input logic [1:0] k, input bit l);
        s_if.tvalid = v;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        bit v;
        drive(0, 16'h0, 2'b00, 0);
        m_if.tready = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_level", 32'(level), 0);
        chk("rst_pkt", 32'(pkt_cnt), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_tvalid", 32'(m_if.tvalid), 0);
        chk("rst_tready", 32'(s_if.tready), 0);
        areset = 1'b0;
        #1;
        chk("tready_before_edge", 32'(s_if.tready), 0);
        step();

        // ---- 1: fill to full with output stalled, then drain ----
        for (int i = 1; i <= 4; i++) begin
            drive(1, 16'(i), 2'b11, 0);
            step();
        end
        chk("t1_full_level", 32'(level), 4);
        drive(1, 16'h0005, 2'b11, 0);
        step();
        drive(0, 16'h0, 2'b00, 0);
        m_if.tready = 1'b1;
        repeat (4) step();
        m_if.tready = 1'b0;

        // ---- 2: continuous stream ----
        m_if.tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1, 16'(16'h0100 + i), 2'b11, (i % 10) == 9);
            step();
        end
        drive(0, 16'h0, 2'b00, 0);
        repeat (2) step();

        // ---- 3: random valid, toggling ready ----
        pushed   = 0;
        obs_pops = 0;
        for (int c = 0; c < 6000 && pushed < 1000; c++) begin
            m_if.tready = (c % 2) == 0;
            v = 1'($urandom % 2);
            drive(v, 16'($urandom), 2'($urandom), 1'($urandom));
            if (v && exp_rdy) pushed++;
            step();
        end
        drive(0, 16'h0, 2'b00, 0);
        m_if.tready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) step();
        chk("t3_pushed", 32'(pushed), 1000);
        chk("t3_popped", 32'(obs_pops), 1000);

        // ---- 4: full plus same-cycle pop ----
        m_if.tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'(16'h0040 + i), 2'b10, 0);
            step();
        end
        m_if.tready = 1'b1;
        drive(1, 16'h0050, 2'b01, 1);
        step();
        chk("t4_ready_after_pop", 32'(s_if.tready), 1);
        m_if.tready = 1'b0;
        step();
        chk("t4_refill_level", 32'(level), 4);
        drive(0, 16'h0, 2'b00, 0);
        m_if.tready = 1'b1;
        repeat (5) step();

        // ---- 5: packets 1,2,1 with output stalled ----
        m_if.tready = 1'b0;
        drive(1, 16'h0061, 2'b11, 1); step();
        drive(1, 16'h0062, 2'b11, 0); step();
        drive(1, 16'h0063, 2'b11, 1); step();
        drive(1, 16'h0064, 2'b01, 1); step();
        drive(0, 16'h0, 2'b00, 0);
        chk("t5_pkt3", 32'(pkt_cnt), 3);
        m_if.tready = 1'b1;
        step();
        chk("t5_pkt2", 32'(pkt_cnt), 2);
        m_if.tready = 1'b0;
        step();
        m_if.tready = 1'b1;
        repeat (3) step();

        // ---- 6: flush at level 3 with a beat on offer ----
        m_if.tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'(16'h0070 + i), 2'b11, i == 1);
            step();
        end
        flush = 1'b1;
        drive(1, 16'h007F, 2'b11, 1);
        step();
        flush = 1'b0;
        drive(0, 16'h0, 2'b00, 0);
        chk("t6_flush_tvalid", 32'(m_if.tvalid), 0);
        chk("t6_flush_level", 32'(level), 0);
        step();

        // ---- 6b: asynchronous reset mid-stream ----
        m_if.tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 16'(16'h0090 + i), 2'b11, 0);
            step();
        end
        chk("t6_pre_rst_tvalid", 32'(m_if.tvalid), 1);
        #3;
        areset = 1'b1;
        #1;
        chk("t6_async_tvalid", 32'(m_if.tvalid), 0);
        chk("t6_async_tready", 32'(s_if.tready), 0);
        chk("t6_async_level", 32'(level), 0);
        q.delete();
        exp_rdy = 1'b0;
        hold    = 1'b0;
        drive(0, 16'h0, 2'b00, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        step();
        drive(1, 16'h00A1, 2'b11, 1);
        step();
        drive(0, 16'h0, 2'b00, 0);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axis_fifo_reg.md
Name: axis_fifo_reg

Overview:
Parametrised AXI-Stream buffer and successor to the two-entry ping-pong register slice. It is generalised to DEPTH entries and configurable byte width, and carries tkeep and tlast. It adds fill-level, almost-full and stored-packet-count status, plus a synchronous flush. It sits between AXIS stages (e.g. ahead of the sum engine) for timing isolation and rate decoupling, with no combinational path between the slave and master sides.

Parameters:
PAR_WDATA_BYTE, 2, tdata width in bytes (1..8); tkeep is PAR_WDATA_BYTE bits
PAR_DEPTH, 4, number of entries; power of two, 2..64
PAR_AFULL, 3, almost_full asserts when level >= PAR_AFULL (1..PAR_DEPTH)

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  asynchronous, active-high reset
flush  in  1  synchronous flush of all contents
s_axis_tdata  in  8*PAR_WDATA_BYTE  input data
s_axis_tkeep  in  PAR_WDATA_BYTE  input byte enables
s_axis_tlast  in  1  input end of packet
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  8*PAR_WDATA_BYTE  output data
m_axis_tkeep  out  PAR_WDATA_BYTE  output byte enables
m_axis_tlast  out  1  output end of packet
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
level  out  $clog2(PAR_DEPTH+1)  stored beats
almost_full  out  1  level >= PAR_AFULL
pkt_cnt  out  $clog2(PAR_DEPTH+1)  stored beats with tlast=1

Behaviour:
- Clock is aclk. Reset is areset: asynchronous, active-high.
- Reset values, applied immediately on areset assertion:
  - wr/rd pointers = 0; level = 0; pkt_cnt = 0; almost_full = 0; m_axis_tvalid = 0.
  - s_axis_tready = 0 while areset is high. It rises at the first aclk edge after areset deasserts.
  - Storage data is not reset.
- Storage: PAR_DEPTH-entry register array, each entry {tdata, tkeep, tlast}.
  - Pointers are log2(PAR_DEPTH)+1 bits; the MSB is the wrap bit.
  - Empty when pointers are equal. Full when the low bits match and the wrap bits differ.
- Push = s_axis_tvalid & s_axis_tready. Pop = m_axis_tvalid & m_axis_tready.
- s_axis_tready = registered !full. It never depends combinationally on m_axis_tready.
- m_axis_tvalid = !empty. m_axis_* come from the entry at the read pointer, driven from flops only (no s_axis -> m_axis combinational path).
- Latency: a beat pushed at edge N into an empty buffer is presented on m_axis after edge N (1 cycle).
- Full throughput: with continuous valid/ready, one beat per cycle in steady state.
- Payload stability: m_axis_tdata/tkeep/tlast are held stable while m_axis_tvalid=1 and m_axis_tready=0.
- Push and pop in the same cycle:
  - level unchanged; both pointers advance.
  - Allowed at any non-full, non-empty level. Allowed at empty only if the push happened in a prior cycle (no bypass).
- When full, tready=0, so no push occurs. A pop in that cycle frees one entry, and tready rises next cycle.
- level: +1 on push only, -1 on pop only, unchanged otherwise.
  - Saturation is impossible by construction; the bench asserts 0 <= level <= PAR_DEPTH.
- pkt_cnt: +1 on push with tlast=1; -1 on pop with m_axis_tlast=1; both in the same cycle = unchanged.
- almost_full: registered, consistent with level in the same cycle.
- tkeep: carried transparently, no checking.
- flush=1 at an edge:
  - Pointers, level and pkt_cnt go to 0. m_axis_tvalid goes to 0 after that edge.
  - Any push or pop in the flush cycle is discarded; the flush has priority.
  - s_axis_tready is 1 after that edge (not full).
- areset mid-packet: contents are lost with no error indication. Upstream must restart the packet.

Test Plan:
1. Reset release, PAR_DEPTH=4, m_axis_tready=0:
   - push 0x0001..0x0004 -> tready drops after 4th push; level=4; almost_full=1 from level 3.
   - then tready=1 -> 0x0001..0x0004 pop in order, one per cycle; level returns to 0.
2. Continuous stream, valid and ready both held 1, 100 beats of incrementing data -> after 1-cycle latency, output matches input every cycle; level stays at 1.
3. Backpressure toggling m_axis_tready 1010... with random s_axis_tvalid, 1000 beats:
   - output sequence identical to input.
   - m_axis payload stable whenever valid=1 and ready=0.
   - no beat lost or duplicated.
4. Full plus same-cycle pop: at level=4, assert m_axis_tready for one cycle -> tready=1 the next cycle; a push then brings level back to 4.
5. Packets: push 3 packets of lengths 1, 2, 1 (tlast on beats 1, 3, 4) with the output stalled:
   - pkt_cnt=3, level=4.
   - popping the first beat -> pkt_cnt=2.
   - tkeep=2'b01 on the last beat arrives unchanged.
6. Flush with level=3 while s_axis_tvalid=1:
   - next cycle m_axis_tvalid=0, level=0, pkt_cnt=0; the beat offered in the flush cycle is not stored.
   - areset asserted mid-stream -> tvalid drops asynchronously.
